// File: rtl/divisor_secuencial.sv
// Iterative restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per cycle.
// Start/busy/done handshake; overflow and divide-by-zero are resolved in a single check cycle.
module divisor_secuencial #(
    parameter int N = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] Dividendo,
    input  logic [N-1:0]   Divisor,
    output logic [N-1:0]   Cociente,
    output logic [N-1:0]   Residuo,
    output logic           busy,
    output logic           done,
    output logic           div_cero,
    output logic           desborde
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CHECK, DIV, FIN} state_t;

    state_t         state, state_next;
    logic [2*N-1:0] dvd;
    logic [N-1:0]   dvs;
    logic [N-1:0]   r;
    logic [N-1:0]   q;
    logic [CW-1:0]  cnt;
    logic           err;
    logic [N:0]     step_res;

    // Returns {quotient bit, new partial remainder}; the remainder stays below the divisor.
    function automatic logic [N:0] restore_step(input logic [N:0] t, input logic [N-1:0] d);
        logic [N:0] diff;
        diff = t - {1'b0, d};
        if (t >= {1'b0, d})
            return {1'b1, diff[N-1:0]};
        else
            return {1'b0, t[N-1:0]};
    endfunction

    assign step_res = restore_step({r, q[N-1]}, dvs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = CHECK;
            CHECK: begin
                if (dvs == '0 || dvd[2*N-1:N] >= dvs)
                    state_next = FIN;
                else
                    state_next = DIV;
            end
            DIV:   if (cnt == CW'(N-1)) state_next = FIN;
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd      <= '0;
            dvs      <= '0;
            r        <= '0;
            q        <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            Cociente <= '0;
            Residuo  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_cero <= 1'b0;
            desborde <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd      <= Dividendo;
                        dvs      <= Divisor;
                        div_cero <= 1'b0;
                        desborde <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CHECK: begin
                    if (dvs == '0) begin
                        div_cero <= 1'b1;
                        desborde <= 1'b0;
                        Cociente <= '1;
                        Residuo  <= '0;
                        err      <= 1'b1;
                    end else if (dvd[2*N-1:N] >= dvs) begin
                        desborde <= 1'b1;
                        Cociente <= '1;
                        Residuo  <= '0;
                        err      <= 1'b1;
                    end else begin
                        r   <= dvd[2*N-1:N];
                        q   <= dvd[N-1:0];
                        cnt <= '0;
                    end
                end
                DIV: begin
                    r   <= step_res[N-1:0];
                    q   <= {q[N-2:0], step_res[N]};
                    cnt <= cnt + 1'b1;
                end
                FIN: begin
                    if (!err) begin
                        Cociente <= q;
                        Residuo  <= r;
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for divisor_secuencial: hand-computed vectors, latency, handshake and reset abort.
module tb_divisor_secuencial;

    localparam int N = 24;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] dividendo;
    logic [N-1:0]   divisor;
    logic [N-1:0]   cociente;
    logic [N-1:0]   residuo;
    logic           busy;
    logic           done;
    logic           div_cero;
    logic           desborde;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    divisor_secuencial #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .Dividendo (dividendo),
        .Divisor   (divisor),
        .Cociente  (cociente),
        .Residuo   (residuo),
        .busy      (busy),
        .done      (done),
        .div_cero  (div_cero),
        .desborde  (desborde)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; presents operands with start for exactly one rising edge (edge 0).
    task automatic launch(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
        dividendo = dvd;
        divisor   = dvs;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Advances a number of edges, recording the first edge (relative) with done high and pulse count.
    task automatic count_done(input int edges, output int lat, output int pulses);
        lat = 0;
        pulses = 0;
        for (int e = 1; e <= edges; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                pulses++;
                if (lat == 0) lat = e;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                          input int exp_lat, input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                          input logic exp_dz, input logic exp_ov);
        int lat, pulses;
        launch(dvd, dvs);
        check({tag, " busy"}, 64'(busy), 64'd1);
        count_done(N + 4, lat, pulses);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " pulses"}, 64'(pulses), 64'd1);
        check({tag, " cociente"}, 64'(cociente), 64'(exp_q));
        check({tag, " residuo"}, 64'(residuo), 64'(exp_r));
        check({tag, " div_cero"}, 64'(div_cero), 64'(exp_dz));
        check({tag, " desborde"}, 64'(desborde), 64'(exp_ov));
        check({tag, " busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat, pulses;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividendo = '0;
        divisor   = '0;
        @(negedge clk);
        check("rst cociente", 64'(cociente), 64'd0);
        check("rst residuo", 64'(residuo), 64'd0);
        check("rst flags", 64'({busy, done, div_cero, desborde}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic", 48'h000000000064, 24'h000007, 26, 24'h00000E, 24'h000002, 1'b0, 1'b0);
        run_op("inverse", 48'hFFFFFE000001, 24'hFFFFFF, 26, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0);
        run_op("overflow", 48'h000010000000, 24'h000010, 2, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1);
        run_op("divzero", 48'h123456789ABC, 24'h000000, 2, 24'hFFFFFF, 24'h000000, 1'b1, 1'b0);
        run_op("div_by_one", 48'h000000ABCDEF, 24'h000001, 26, 24'hABCDEF, 24'h000000, 1'b0, 1'b0);
        run_op("max_quot", 48'h000006FFFFFF, 24'h000007, 26, 24'hFFFFFF, 24'h000006, 1'b0, 1'b0);
        run_op("ovf_equal", 48'h000007000000, 24'h000007, 2, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1);

        // Handshake: starts at edges 5 and 26 are ignored, edge 27 is accepted.
        launch(48'h000000000064, 24'h000007);
        count_done(4, lat, pulses);
        dividendo = 48'h000000ABCDEF;
        divisor   = 24'h000001;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        count_done(20, lat, pulses);
        check("hs early_done", 64'(pulses), 64'd0);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("hs done_edge26", 64'(done), 64'd1);
        check("hs cociente", 64'(cociente), 64'h00000E);
        check("hs residuo", 64'(residuo), 64'h000002);
        launch(48'h000000ABCDEF, 24'h000001);
        check("hs accept27 busy", 64'(busy), 64'd1);
        check("hs accept27 done", 64'(done), 64'd0);
        count_done(N + 4, lat, pulses);
        check("hs second latency", 64'(lat), 64'd26);
        check("hs second pulses", 64'(pulses), 64'd1);
        check("hs second cociente", 64'(cociente), 64'hABCDEF);

        // Reset during the multiplier-inverse run aborts it without a done pulse.
        launch(48'hFFFFFE000001, 24'hFFFFFF);
        count_done(9, lat, pulses);
        check("rstmid pre pulses", 64'(pulses), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rstmid cociente", 64'(cociente), 64'd0);
        check("rstmid residuo", 64'(residuo), 64'd0);
        check("rstmid flags", 64'({busy, done, div_cero, desborde}), 64'd0);
        count_done(3, lat, pulses);
        rst_n = 1'b1;
        count_done(N + 4, lat, pulses);
        check("rstmid no done", 64'(pulses), 64'd0);
        run_op("after_rst", 48'h000000000064, 24'h000007, 26, 24'h00000E, 24'h000002, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
